// File: rtl/painterengine_gpu_dma_pkg.sv
// rtl/painterengine_gpu_dma_pkg.sv - shared states, error codes and constants for the GPU DMA multi-reader
package painterengine_gpu_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_PARAM_CHECK = 3'd1,
      ST_CALC        = 3'd2,
      ST_ADDR        = 3'd3,
      ST_DATA        = 3'd4,
      ST_DONE        = 3'd5,
      ST_ERROR       = 3'd6
   } dma_state_e;

   typedef enum logic [2:0] {
      ERR_OK         = 3'd0,
      ERR_ROUTER     = 3'd1,
      ERR_ADDRESS    = 3'd2,
      ERR_AR_TIMEOUT = 3'd3,
      ERR_R_TIMEOUT  = 3'd4,
      ERR_PROTOCOL   = 3'd5,
      ERR_SLAVE      = 3'd6,
      ERR_RESERVED   = 3'd7
   } dma_error_e;

   localparam logic [31:0] BOUNDARY_4K   = 32'h0000_1000;
   localparam logic [3:0]  AR_CACHE      = 4'b0010;
   localparam logic [1:0]  AR_BURST_INCR = 2'b01;

   // Index of the lowest set bit; 0 when nothing is set.
   function automatic logic [2:0] lowest_index(input logic [7:0] v);
      lowest_index = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_index = 3'(i);
      end
   endfunction

endpackage

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// rtl/painterengine_gpu_dma_burst_calc.sv - next burst length limited by remaining beats, burst window and 4 KiB page
module painterengine_gpu_dma_burst_calc
   import painterengine_gpu_dma_pkg::*;
#(
   parameter int P_DATA_WIDTH = 32,
   parameter int P_MAX_BURST  = 256
) (
   input  logic [31:0] addr_i,
   input  logic [31:0] remaining_i,
   output logic [8:0]  burst_len_o
);

   localparam int BEAT_SHIFT = $clog2(P_DATA_WIDTH / 8);

   logic [31:0] beat_idx;
   logic [31:0] window_room;
   logic [31:0] page_room;
   logic [31:0] limit;

   always_comb begin
      beat_idx    = addr_i >> BEAT_SHIFT;
      window_room = 32'(P_MAX_BURST) - (beat_idx & 32'(P_MAX_BURST - 1));
      page_room   = (BOUNDARY_4K - (addr_i & (BOUNDARY_4K - 32'd1))) >> BEAT_SHIFT;
      limit       = (window_room < page_room) ? window_room : page_room;
      if (remaining_i < limit) limit = remaining_i;
      burst_len_o = 9'(limit);
   end

endmodule

// File: rtl/painterengine_gpu_dma_multi_reader.sv
// rtl/painterengine_gpu_dma_multi_reader.sv - AXI read DMA splitting transfers into bursts and steering data to one channel
module painterengine_gpu_dma_multi_reader
   import painterengine_gpu_dma_pkg::*;
#(
   parameter int P_CHANNELS     = 4,
   parameter int P_DATA_WIDTH   = 32,
   parameter int P_MAX_BURST    = 256,
   parameter int P_TIMEOUT_BITS = 19
) (
   input  logic                               i_wire_clock,
   input  logic                               i_wire_resetn,
   input  logic                               i_wire_start,
   input  logic [P_CHANNELS-1:0]              i_wire_router,
   input  logic [P_CHANNELS*32-1:0]           i_wire_address,
   input  logic [P_CHANNELS*32-1:0]           i_wire_length,
   output logic                               o_wire_busy,
   output logic                               o_wire_done,
   output logic                               o_wire_error,
   output logic [2:0]                         o_wire_error_type,
   output logic [31:0]                        o_wire_beat_count,
   output logic [P_CHANNELS*P_DATA_WIDTH-1:0] o_wire_data,
   output logic [P_CHANNELS-1:0]              o_wire_data_valid,
   input  logic [P_CHANNELS-1:0]              i_wire_data_next,
   output logic [31:0]                        o_wire_M_AXI_ARADDR,
   output logic [7:0]                         o_wire_M_AXI_ARLEN,
   output logic [2:0]                         o_wire_M_AXI_ARSIZE,
   output logic [1:0]                         o_wire_M_AXI_ARBURST,
   output logic                               o_wire_M_AXI_ARVALID,
   output logic                               o_wire_M_AXI_ARID,
   output logic                               o_wire_M_AXI_ARLOCK,
   output logic [3:0]                         o_wire_M_AXI_ARCACHE,
   output logic [2:0]                         o_wire_M_AXI_ARPROT,
   output logic [3:0]                         o_wire_M_AXI_ARQOS,
   input  logic                               i_wire_M_AXI_ARREADY,
   input  logic                               i_wire_M_AXI_RID,
   input  logic [P_DATA_WIDTH-1:0]            i_wire_M_AXI_RDATA,
   input  logic [1:0]                         i_wire_M_AXI_RRESP,
   input  logic                               i_wire_M_AXI_RLAST,
   input  logic                               i_wire_M_AXI_RVALID,
   output logic                               o_wire_M_AXI_RREADY
);

   localparam int BEAT_BYTES = P_DATA_WIDTH / 8;

   dma_state_e                state_q, state_d;
   dma_error_e                err_q, err_d;
   logic [P_CHANNELS-1:0]     router_q, router_d;
   logic [31:0]               addr_q, addr_d;
   logic [31:0]               remaining_q, remaining_d;
   logic [31:0]               beat_count_q, beat_count_d;
   logic [7:0]                arlen_q, arlen_d;
   logic [8:0]                burst_cnt_q, burst_cnt_d;
   logic [P_TIMEOUT_BITS-1:0] stall_q, stall_d;

   logic        start_ok, rready, r_beat, stall_expired, misaligned;
   logic [2:0]  chan_idx, start_idx;
   logic [31:0] start_addr, start_len;
   logic [8:0]  burst_len;
   logic        unused_rid;

   assign unused_rid    = i_wire_M_AXI_RID;
   assign start_idx     = lowest_index(8'(i_wire_router));
   assign chan_idx      = lowest_index(8'(router_q));
   assign start_ok      = i_wire_start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
   assign r_beat        = i_wire_M_AXI_RVALID && rready;
   assign stall_expired = stall_q[P_TIMEOUT_BITS-1];
   assign misaligned    = |(addr_q & 32'(BEAT_BYTES - 1));

   painterengine_gpu_dma_burst_calc #(
      .P_DATA_WIDTH (P_DATA_WIDTH),
      .P_MAX_BURST  (P_MAX_BURST)
   ) u_burst_calc (
      .addr_i      (addr_q),
      .remaining_i (remaining_q),
      .burst_len_o (burst_len)
   );

   always_comb begin
      start_addr = '0;
      start_len  = '0;
      for (int c = 0; c < P_CHANNELS; c++) begin
         if (start_idx == 3'(c)) begin
            start_addr = i_wire_address[c*32 +: 32];
            start_len  = i_wire_length[c*32 +: 32];
         end
      end
   end

   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state_q      <= ST_IDLE;
         err_q        <= ERR_OK;
         router_q     <= '0;
         addr_q       <= '0;
         remaining_q  <= '0;
         beat_count_q <= '0;
         arlen_q      <= '0;
         burst_cnt_q  <= '0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         err_q        <= err_d;
         router_q     <= router_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         beat_count_q <= beat_count_d;
         arlen_q      <= arlen_d;
         burst_cnt_q  <= burst_cnt_d;
         stall_q      <= stall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_ok) begin
               state_d = ST_PARAM_CHECK;
               err_d   = ERR_OK;
            end
         end
         ST_PARAM_CHECK: begin
            if (!$onehot(router_q)) begin
               state_d = ST_ERROR;
               err_d   = ERR_ROUTER;
            end else if (remaining_q == '0 || misaligned) begin
               state_d = ST_ERROR;
               err_d   = ERR_ADDRESS;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_CALC: state_d = ST_ADDR;
         ST_ADDR: begin
            if (i_wire_M_AXI_ARREADY) begin
               state_d = ST_DATA;
            end else if (stall_expired) begin
               state_d = ST_ERROR;
               err_d   = ERR_AR_TIMEOUT;
            end
         end
         ST_DATA: begin
            // A slave error outranks a framing error on the same beat.
            if (r_beat) begin
               if (i_wire_M_AXI_RRESP != 2'b00) begin
                  state_d = ST_ERROR;
                  err_d   = ERR_SLAVE;
               end else if ((burst_cnt_q == 9'd1) != i_wire_M_AXI_RLAST) begin
                  state_d = ST_ERROR;
                  err_d   = ERR_PROTOCOL;
               end else if (burst_cnt_q == 9'd1) begin
                  state_d = (remaining_q == 32'd1) ? ST_DONE : ST_CALC;
               end
            end else if (stall_expired) begin
               state_d = ST_ERROR;
               err_d   = ERR_R_TIMEOUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      router_d     = router_q;
      addr_d       = addr_q;
      remaining_d  = remaining_q;
      beat_count_d = beat_count_q;
      arlen_d      = arlen_q;
      burst_cnt_d  = burst_cnt_q;
      stall_d      = stall_q;
      if (start_ok) begin
         router_d     = i_wire_router;
         addr_d       = start_addr;
         remaining_d  = start_len;
         beat_count_d = '0;
         stall_d      = '0;
      end
      case (state_q)
         ST_CALC: begin
            arlen_d = 8'(burst_len - 9'd1);
            stall_d = '0;
         end
         ST_ADDR: begin
            if (i_wire_M_AXI_ARREADY) begin
               burst_cnt_d = {1'b0, arlen_q} + 9'd1;
               stall_d     = '0;
            end else begin
               stall_d = stall_q + P_TIMEOUT_BITS'(1);
            end
         end
         ST_DATA: begin
            if (r_beat) begin
               addr_d       = addr_q + 32'(BEAT_BYTES);
               remaining_d  = remaining_q - 32'd1;
               beat_count_d = beat_count_q + 32'd1;
               burst_cnt_d  = burst_cnt_q - 9'd1;
               stall_d      = '0;
            end else begin
               stall_d = stall_q + P_TIMEOUT_BITS'(1);
            end
         end
         default: ;
      endcase
   end

   // Steering follows the channel latched at start, never the live router.
   always_comb begin
      o_wire_busy          = state_q inside {ST_PARAM_CHECK, ST_CALC, ST_ADDR, ST_DATA};
      o_wire_done          = (state_q == ST_DONE);
      o_wire_error         = (state_q == ST_ERROR);
      o_wire_M_AXI_ARVALID = (state_q == ST_ADDR);
      rready               = 1'b0;
      o_wire_data          = '0;
      o_wire_data_valid    = '0;
      for (int c = 0; c < P_CHANNELS; c++) begin
         if (state_q == ST_DATA && chan_idx == 3'(c)) begin
            rready                                      = i_wire_data_next[c];
            o_wire_data[c*P_DATA_WIDTH +: P_DATA_WIDTH] = i_wire_M_AXI_RDATA;
            o_wire_data_valid[c]                        = i_wire_M_AXI_RVALID;
         end
      end
   end

   assign o_wire_M_AXI_RREADY  = rready;
   assign o_wire_error_type    = err_q;
   assign o_wire_beat_count    = beat_count_q;
   assign o_wire_M_AXI_ARADDR  = addr_q;
   assign o_wire_M_AXI_ARLEN   = arlen_q;
   assign o_wire_M_AXI_ARSIZE  = 3'($clog2(BEAT_BYTES));
   assign o_wire_M_AXI_ARBURST = AR_BURST_INCR;
   assign o_wire_M_AXI_ARID    = 1'b0;
   assign o_wire_M_AXI_ARLOCK  = 1'b0;
   assign o_wire_M_AXI_ARCACHE = AR_CACHE;
   assign o_wire_M_AXI_ARPROT  = 3'b000;
   assign o_wire_M_AXI_ARQOS   = 4'b0000;

endmodule

// File: tb/tb_painterengine_gpu_dma_multi_reader.sv
// tb/tb_painterengine_gpu_dma_multi_reader.sv - directed and randomized bench with burst-plan reference model
module tb_painterengine_gpu_dma_multi_reader;

   localparam int TB_TIMEOUT_BITS = 8;
   localparam int BUDGET          = 5000;

   logic         clk = 1'b0;
   logic         resetn;
   logic         start;
   logic [3:0]   router_in;
   logic [127:0] addr_bus, len_bus;
   logic         busy, done, err;
   logic [2:0]   err_type;
   logic [31:0]  beat_count;
   logic [127:0] data;
   logic [3:0]   data_valid, data_next;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize, arprot;
   logic [1:0]   arburst;
   logic         arvalid, arid, arlock;
   logic [3:0]   arcache, arqos;
   logic         arready, rid, rlast, rvalid, rready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   painterengine_gpu_dma_multi_reader #(
      .P_CHANNELS     (4),
      .P_DATA_WIDTH   (32),
      .P_MAX_BURST    (256),
      .P_TIMEOUT_BITS (TB_TIMEOUT_BITS)
   ) dut (
      .i_wire_clock         (clk),
      .i_wire_resetn        (resetn),
      .i_wire_start         (start),
      .i_wire_router        (router_in),
      .i_wire_address       (addr_bus),
      .i_wire_length        (len_bus),
      .o_wire_busy          (busy),
      .o_wire_done          (done),
      .o_wire_error         (err),
      .o_wire_error_type    (err_type),
      .o_wire_beat_count    (beat_count),
      .o_wire_data          (data),
      .o_wire_data_valid    (data_valid),
      .i_wire_data_next     (data_next),
      .o_wire_M_AXI_ARADDR  (araddr),
      .o_wire_M_AXI_ARLEN   (arlen),
      .o_wire_M_AXI_ARSIZE  (arsize),
      .o_wire_M_AXI_ARBURST (arburst),
      .o_wire_M_AXI_ARVALID (arvalid),
      .o_wire_M_AXI_ARID    (arid),
      .o_wire_M_AXI_ARLOCK  (arlock),
      .o_wire_M_AXI_ARCACHE (arcache),
      .o_wire_M_AXI_ARPROT  (arprot),
      .o_wire_M_AXI_ARQOS   (arqos),
      .i_wire_M_AXI_ARREADY (arready),
      .i_wire_M_AXI_RID     (rid),
      .i_wire_M_AXI_RDATA   (rdata),
      .i_wire_M_AXI_RRESP   (rresp),
      .i_wire_M_AXI_RLAST   (rlast),
      .i_wire_M_AXI_RVALID  (rvalid),
      .o_wire_M_AXI_RREADY  (rready)
   );

   task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_error"}, err, 0);
      check({pfx, "_error_type"}, err_type, 0);
      check({pfx, "_beat_count"}, beat_count, 0);
      check({pfx, "_arvalid"}, arvalid, 0);
      check({pfx, "_rready"}, rready, 0);
      check({pfx, "_araddr"}, araddr, 0);
      check({pfx, "_arlen"}, arlen, 0);
      check({pfx, "_data_valid"}, data_valid, 0);
      check({pfx, "_data"}, data, 0);
   endtask

   // Plays the AXI slave and the consumer, predicting bursts from the transfer parameters.
   task automatic do_transfer(input logic [3:0] router, input logic [31:0] addr, input logic [31:0] len,
                              input bit rnd, input int bad_beat, input bit ar_block,
                              input int abort_after, output bit aborted);
      logic [31:0] q_addr[$];
      int          q_len[$];
      int          exp_err, ch, pending, beat_in_burst, cur_len, beats, ar_cycles;
      bit          finished, onehot, hs;
      logic [31:0] a, r, n, win, pg;
      logic [3:0]  next_v;
      logic [127:0] mask;
      aborted = 0;
      ch = 0;
      for (int i = 3; i >= 0; i--) if (router[i]) ch = i;
      onehot = (router != 4'd0) && ((router & (router - 4'd1)) == 4'd0);
      if (!onehot) exp_err = 1;
      else if (len == 0 || addr % 4 != 0) exp_err = 2;
      else if (ar_block) exp_err = 3;
      else if (bad_beat >= 0 && bad_beat < int'(len)) exp_err = 6;
      else exp_err = 0;
      if (exp_err == 0 || exp_err >= 3) begin
         a = addr;
         r = len;
         while (r > 0) begin
            win = 32'd256 - ((a / 4) % 256);
            pg  = (32'd4096 - (a % 4096)) / 4;
            n = r;
            if (win < n) n = win;
            if (pg < n) n = pg;
            q_addr.push_back(a);
            q_len.push_back(int'(n));
            a = a + n * 4;
            r = r - n;
         end
      end

      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         addr_bus[i*32 +: 32] = $urandom;
         len_bus[i*32 +: 32]  = $urandom;
      end
      addr_bus[ch*32 +: 32] = addr;
      len_bus[ch*32 +: 32]  = len;
      router_in = router;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      router_in = 4'($urandom);
      addr_bus  = {$urandom, $urandom, $urandom, $urandom};
      len_bus   = {$urandom, $urandom, $urandom, $urandom};

      pending = 0; beats = 0; ar_cycles = 0; finished = 0; beat_in_burst = 0; cur_len = 0;
      for (int cyc = 0; cyc < BUDGET; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (abort_after >= 0 && beats >= abort_after) begin
            aborted = 1;
            break;
         end
         if (done || err) begin
            finished = 1;
            break;
         end
         if (rnd && cyc == 3 && busy) begin
            router_in = 4'b0011;
            start     = 1'b1;
         end else begin
            start = 1'b0;
         end
         arready = ar_block ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
         next_v  = rnd ? 4'($urandom) : 4'hF;
         rdata   = $urandom;
         rresp   = 2'd0;
         rlast   = 1'b0;
         rvalid  = 1'b0;
         if (pending > 0) begin
            rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            rlast  = (beat_in_burst == cur_len - 1);
            if (beats == bad_beat) begin
               rresp     = 2'd2;
               rvalid    = 1'b1;
               next_v[ch] = 1'b1;
            end
         end
         data_next = next_v;
         #1;
         hs = (pending > 0) && rvalid && next_v[ch];
         check("rready", rready, (pending > 0) ? next_v[ch] : 1'b0);
         check("data_valid", data_valid, (pending > 0 && rvalid) ? router : 4'd0);
         if (pending > 0) begin
            mask = 128'hFFFF_FFFF << (ch * 32);
            check("data_sel", (data >> (ch * 32)) & 128'hFFFF_FFFF, {96'd0, rdata});
            check("data_other", data & ~mask, 128'd0);
         end
         if (hs) begin
            beats++;
            beat_in_burst++;
            pending--;
         end
         if (arvalid) begin
            ar_cycles++;
            if (arready) begin
               check("ar_expected", q_addr.size() > 0, 1);
               if (q_addr.size() > 0) begin
                  check("araddr", araddr, q_addr[0]);
                  check("arlen", arlen, q_len[0] - 1);
                  pending       = q_len[0];
                  cur_len       = q_len[0];
                  beat_in_burst = 0;
                  void'(q_addr.pop_front());
                  void'(q_len.pop_front());
               end
            end
         end
      end
      start = 1'b0;
      if (aborted) return;

      check("finished_in_budget", finished, 1);
      check("done", done, exp_err == 0);
      check("error", err, exp_err != 0);
      check("error_type", err_type, exp_err);
      check("beat_count", beat_count, (exp_err == 0) ? len : ((exp_err == 6) ? 32'(bad_beat + 1) : 32'd0));
      check("busy_end", busy, 0);
      if (exp_err == 0) check("bursts_left", q_addr.size(), 0);
      if (exp_err == 1 || exp_err == 2) check("arvalid_never", ar_cycles, 0);
      if (exp_err == 3) check("ar_stall_window", (ar_cycles >= 128 && ar_cycles <= 130), 1);
      rvalid    = 1'b0;
      rlast     = 1'b0;
      rresp     = 2'd0;
      data_next = 4'hF;
      arready   = 1'b1;
      #1;
      check("rready_after_end", rready, 0);
      repeat (3) @(negedge clk);
      check("sticky_done", done, exp_err == 0);
      check("sticky_error", err, exp_err != 0);
      check("sticky_error_type", err_type, exp_err);
   endtask

   initial begin
      bit          aborted;
      logic [3:0]  rr;
      logic [31:0] ra, rl;
      resetn = 1'b0; start = 1'b0; router_in = '0; addr_bus = '0; len_bus = '0;
      data_next = '0; arready = 1'b0; rid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset");
      check("arsize", arsize, 3'd2);
      check("arburst", arburst, 2'b01);
      check("arcache", arcache, 4'b0010);
      check("ar_tieoffs", {arid, arlock, arprot, arqos}, 0);
      @(negedge clk);
      resetn = 1'b1;

      do_transfer(4'b0100, 32'h0000_1000, 32'd600, 0, -1, 0, -1, aborted);
      do_transfer(4'b0001, 32'h0000_0FF0, 32'd8, 0, -1, 0, -1, aborted);
      do_transfer(4'b0011, 32'h0000_1000, 32'd4, 0, -1, 0, -1, aborted);
      do_transfer(4'b0001, 32'h0000_2000, 32'd1, 0, -1, 0, -1, aborted);
      do_transfer(4'b1000, 32'h0000_1002, 32'd4, 0, -1, 0, -1, aborted);
      do_transfer(4'b0010, 32'h0000_1000, 32'd0, 0, -1, 0, -1, aborted);
      do_transfer(4'b0010, 32'h0000_2000, 32'd20, 1, 4, 0, -1, aborted);
      do_transfer(4'b1000, 32'h0000_3000, 32'd4, 0, -1, 1, -1, aborted);

      for (int t = 0; t < 6; t++) begin
         rr = 4'(1 << $urandom_range(0, 3));
         ra = 32'($urandom_range(0, 15)) * 32'h1000 + 32'($urandom_range(0, 1023)) * 32'd4;
         rl = 32'($urandom_range(1, 700));
         do_transfer(rr, ra, rl, 1, -1, 0, -1, aborted);
      end

      do_transfer(4'b0010, 32'h0000_4000, 32'd300, 0, -1, 0, 10, aborted);
      check("aborted_mid_data", aborted, 1);
      rvalid    = 1'b1;
      data_next = 4'hF;
      #1;
      check("rready_before_reset", rready, 1);
      resetn = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      #1;
      check_all_zero("held_reset");
      @(negedge clk);
      rvalid = 1'b0;
      resetn = 1'b1;

      do_transfer(4'b1000, 32'h0000_5FF8, 32'd40, 1, -1, 0, -1, aborted);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
